// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel word handshake (in_data/in_valid/in_ready) and serial bit stream (ser_data/ser_valid/ser_ready/ser_last)
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic ser_data;
  logic ser_valid;
  logic ser_ready;
  logic ser_last;
  modport master (output in_data, in_valid, ser_ready, input in_ready, ser_data, ser_valid, ser_last);
  modport slave (input in_data, in_valid, ser_ready, output in_ready, ser_data, ser_valid, ser_last);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: buffered PISO; ports clk, reset_n (sync active-low), bus (word in, bit stream out), busy, words_sent
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  piso_serializer_if.slave bus,
  output logic busy,
  output logic [CNT_W-1:0] words_sent
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx, hold, hold_nx;
  logic hold_full, hold_full_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic accept, consume, last, free;
  assign bus.in_ready = !hold_full;
  assign bus.ser_valid = state == SHIFT;
  assign bus.ser_last = last;
  assign bus.ser_data = MSB_FIRST != 0 ? sh[WIDTH-1] : sh[0];
  assign accept = bus.in_valid & !hold_full;
  assign consume = bus.ser_valid & bus.ser_ready;
  assign last = bus.ser_valid & (bit_cnt == LAST);
  assign free = (state == IDLE) | (consume & last);
  assign busy = (state == SHIFT) | hold_full;
  // accept is impossible while hold is full, so a free shifter drains hold or takes the new word, never both
  always_comb begin
    state_nx = state;
    sh_nx = sh;
    hold_nx = hold;
    hold_full_nx = hold_full;
    bit_cnt_nx = bit_cnt;
    if (free) begin
      bit_cnt_nx = '0;
      state_nx = (hold_full | accept) ? SHIFT : IDLE;
      sh_nx = hold_full ? hold : accept ? bus.in_data : '0;
      hold_full_nx = 1'b0;
    end else begin
      if (consume) begin
        bit_cnt_nx = bit_cnt + 1'b1;
        sh_nx = MSB_FIRST != 0 ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
      end
      if (accept) begin
        hold_nx = bus.in_data;
        hold_full_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      sh <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      bit_cnt <= '0;
      words_sent <= '0;
    end else begin
      state <= state_nx;
      sh <= sh_nx;
      hold <= hold_nx;
      hold_full <= hold_full_nx;
      bit_cnt <= bit_cnt_nx;
      if (consume & last) words_sent <= words_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector-table and directed-sequence bench for piso_serializer (MSB-first and LSB-first instances)
module tb_piso_serializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  piso_serializer_if #(.WIDTH(8)) a ();
  piso_serializer_if #(.WIDTH(8)) b ();
  logic busy_a, busy_b;
  logic [15:0] ws_a;
  logic [1:0] ws_b;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a.slave), .busy(busy_a), .words_sent(ws_a));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b.slave), .busy(busy_b), .words_sent(ws_b));
  typedef struct {
    bit sel;
    logic [7:0] data;
    logic [7:0] seq;
    logic [15:0] ws;
  } vec_t;
  vec_t tbl[7];
  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit sel, input logic [7:0] d, output logic [7:0] seq,
                      output logic [7:0] lasts, output logic first_ok);
    int n;
    n = 0;
    seq = '0;
    lasts = '0;
    if (sel) begin b.in_data = d; b.in_valid = 1'b1; end
    else begin a.in_data = d; a.in_valid = 1'b1; end
    tick();
    if (sel) b.in_valid = 1'b0;
    else a.in_valid = 1'b0;
    first_ok = sel ? b.ser_valid : a.ser_valid;
    for (int c = 0; c < 20 && n < 8; c++) begin
      if (sel ? b.ser_valid : a.ser_valid) begin
        seq[7-n] = sel ? b.ser_data : a.ser_data;
        lasts[7-n] = sel ? b.ser_last : a.ser_last;
        n++;
      end
      tick();
    end
    check("bits_collected", n, 8);
  endtask
  initial begin
    logic [7:0] seq, lasts;
    logic first_ok, acc, dropped, started, froze_ok;
    logic [15:0] s16;
    int n, gaps, nacc, stalls;
    tbl[0] = '{1'b0, 8'hA5, 8'b10100101, 16'd1};
    tbl[1] = '{1'b0, 8'hC3, 8'b11000011, 16'd2};
    tbl[2] = '{1'b1, 8'h01, 8'b10000000, 16'd1};
    tbl[3] = '{1'b1, 8'h80, 8'b00000001, 16'd2};
    tbl[4] = '{1'b1, 8'hB4, 8'b00101101, 16'd3};
    tbl[5] = '{1'b1, 8'hFF, 8'b11111111, 16'd0};
    tbl[6] = '{1'b1, 8'h06, 8'b01100000, 16'd1};
    a.in_data = 8'hAA; a.in_valid = 1'b1; a.ser_ready = 1'b1;
    b.in_data = 8'h00; b.in_valid = 1'b0; b.ser_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", a.in_ready, 1);
    check("rst_ser_valid", a.ser_valid, 0);
    check("rst_ser_data", a.ser_data, 0);
    check("rst_ser_last", a.ser_last, 0);
    check("rst_busy", busy_a, 0);
    check("rst_words_sent", ws_a, 0);
    check("rst_b_ser_valid", b.ser_valid, 0);
    a.in_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    check("post_rst_no_accept", a.ser_valid, 0);
    check("post_rst_busy", busy_a, 0);
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].sel, tbl[i].data, seq, lasts, first_ok);
      check($sformatf("tbl%0d_first_valid", i), first_ok, 1);
      check($sformatf("tbl%0d_seq", i), seq, tbl[i].seq);
      check($sformatf("tbl%0d_last", i), lasts, 8'h01);
      check($sformatf("tbl%0d_words", i), tbl[i].sel ? 16'(ws_b) : ws_a, tbl[i].ws);
    end
    n = 0; gaps = 0; nacc = 0; dropped = 1'b0; started = 1'b0; s16 = '0;
    a.in_data = 8'h3C; a.in_valid = 1'b1;
    for (int c = 0; c < 40 && n < 16; c++) begin
      acc = a.in_valid & a.in_ready;
      if (a.ser_valid) begin
        started = 1'b1;
        s16[15-n] = a.ser_data;
        n++;
      end else if (started) gaps++;
      if (busy_a && !a.in_ready) dropped = 1'b1;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) a.in_data = 8'hFF;
        else a.in_valid = 1'b0;
      end
    end
    check("b2b_bits", n, 16);
    check("b2b_seq", s16, 16'h3CFF);
    check("b2b_gaps", gaps, 0);
    check("b2b_ready_dropped", dropped, 1);
    check("b2b_words", ws_a, 16'd4);
    a.in_data = 8'h81; a.in_valid = 1'b1;
    tick();
    a.in_valid = 1'b0;
    n = 0; stalls = 0; froze_ok = 1'b1; seq = '0;
    for (int c = 0; c < 30 && n < 8; c++) begin
      a.ser_ready = (n == 4 && stalls < 3) ? 1'b0 : 1'b1;
      if (a.ser_ready) begin
        if (a.ser_valid) begin
          seq[7-n] = a.ser_data;
          n++;
        end
      end else begin
        stalls++;
        if (a.ser_data !== 1'b0 || a.ser_valid !== 1'b1 || a.ser_last !== 1'b0) froze_ok = 1'b0;
      end
      tick();
    end
    a.ser_ready = 1'b1;
    check("stall_bits", n, 8);
    check("stall_cycles", stalls, 3);
    check("stall_frozen", froze_ok, 1);
    check("stall_seq", seq, 8'b10000001);
    check("stall_words", ws_a, 16'd5);
    a.in_data = 8'hF0; a.in_valid = 1'b1;
    tick();
    a.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("midrst_busy_before", busy_a, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_ser_valid", a.ser_valid, 0);
    check("midrst_words", ws_a, 16'd0);
    check("midrst_busy", busy_a, 0);
    check("midrst_in_ready", a.in_ready, 1);
    send(1'b0, 8'h0F, seq, lasts, first_ok);
    check("after_rst_first_valid", first_ok, 1);
    check("after_rst_seq", seq, 8'b00001111);
    check("after_rst_last", lasts, 8'h01);
    check("after_rst_words", ws_a, 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
